// File: rtl/pipeline_skid_buffer_if.sv
// Purpose: ready/valid handshake bundle around a two-entry skid buffer.
// Latency: none (wires only).
// Backpressure: carries input_ready upstream and output_ready downstream.
//
// Ports/signals:
//   input_valid, input_data, input_ready     - upstream side of the buffer
//   output_valid, output_data, output_ready  - downstream side of the buffer
// Modports:
//   slave  - the buffer itself (consumes input_*, produces output_*)
//   master - the environment around the buffer (producer and consumer)
interface pipeline_skid_buffer_if #(
    parameter int WORD_WIDTH = 0
);
    logic                  input_valid;
    logic                  input_ready;
    logic [WORD_WIDTH-1:0] input_data;
    logic                  output_valid;
    logic                  output_ready;
    logic [WORD_WIDTH-1:0] output_data;

    modport slave (
        input  input_valid,
        input  input_data,
        output input_ready,
        output output_valid,
        input  output_ready,
        output output_data
    );

    modport master (
        output input_valid,
        output input_data,
        input  input_ready,
        input  output_valid,
        output output_ready,
        input  output_data
    );
endinterface

// File: rtl/pipeline_skid_buffer.sv
// Purpose: two-entry ready/valid buffer with fully registered valid/ready/data, cutting the ready path.
// Latency: a word inserted on edge N is presented on output_data after edge N (1 cycle), full throughput.
// Backpressure: input_ready drops only when both entries are full (never with PIPELINE_SKID_BUFFER_CIRCULAR_EN).
//
// Ports:
//   clock  - single clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset; discards both stored words
//   bus    - pipeline_skid_buffer_if.slave: input_valid/input_ready/input_data upstream,
//            output_valid/output_ready/output_data downstream
// Parameter WORD_WIDTH must be set > 0 and match the interface instance.
// Optional macro PIPELINE_SKID_BUFFER_CIRCULAR_EN: when defined, the buffer never back-pressures
// after reset; inserting into a full buffer without a removal drops the oldest word.
module pipeline_skid_buffer #(
    parameter int WORD_WIDTH = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    pipeline_skid_buffer_if.slave       bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] main_q,  main_d;
    logic [WORD_WIDTH-1:0] skid_q,  skid_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;

    logic insert;
    logic remove;

    // Handshakes use only the registered ready/valid, so output_ready never
    // reaches input_ready through logic.
    assign insert = bus.input_valid & ready_q;
    assign remove = valid_q & bus.output_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (insert) begin
                    main_d  = bus.input_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (insert && !remove) begin
                    skid_d  = bus.input_data;
                    state_d = FULL;
                end else if (insert && remove) begin
                    // Flow-through: the new word replaces the one leaving.
                    main_d  = bus.input_data;
                end else if (remove) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
`ifdef PIPELINE_SKID_BUFFER_CIRCULAR_EN
                if (insert) begin
                    // Shift the pair forward; without a removal the word
                    // in main is lost (oldest dropped).
                    main_d = skid_q;
                    skid_d = bus.input_data;
                end else if (remove) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
`else
                // input_ready is low here, so input_data is ignored.
                if (remove) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
`endif
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Ready/valid are registered copies of what the next state implies.
        // ready_q is 0 only while reset is held; the first edge after
        // release sets it.
`ifdef PIPELINE_SKID_BUFFER_CIRCULAR_EN
        ready_d = 1'b1;
`else
        ready_d = (state_d != FULL);
`endif
        valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.input_ready  = ready_q;
    assign bus.output_valid = valid_q;
    assign bus.output_data  = main_q;

endmodule
